// File: rtl/cordic_mag_avg.sv
// cordic_mag_avg: windowed mean (and optional peak) of the cordic magnitude
// stream, with results queued in a first-word-fall-through FIFO.
//
// Optional feature macro: CORDIC_MAG_PEAK_EN (window peak tracking).
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   valid_i    data_i holds a magnitude sample
//   data_i     unsigned magnitude, Q_I.Q_F
//   clear_i    drop the partial window and clear overflow_o
//   valid_o    FIFO head holds a result
//   ready_i    sink accepts the head
//   mean_o     window mean at the FIFO head
//   peak_o     window maximum at the FIFO head (0 without CORDIC_MAG_PEAK_EN)
//   count_o    FIFO fill level
//   overflow_o sticky: a completed window was dropped
module cordic_mag_avg #(
    parameter int Q_I        = 15,
    parameter int Q_F        = 16,
    parameter int LOG2_WIN   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int WIDTH     = Q_I + Q_F + 1,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] mean_o,
    output logic [WIDTH-1:0] peak_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = WIDTH + LOG2_WIN;

    logic [SW-1:0]       acc;
    logic [LOG2_WIN-1:0] cnt;
    logic [SW-1:0]       sum;
    logic [WIDTH-1:0]    mean_next;
    logic                win_last;
    logic                take;
    logic                push;
    logic                pop;
    logic                full;
    logic                wr_en;

    logic [WIDTH-1:0]    mean_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                ovf;

    // Accumulator is wide enough for WIN full-scale samples.
    assign sum       = acc + SW'(data_i);
    assign mean_next = WIDTH'(sum >> LOG2_WIN);
    assign win_last  = (cnt == {LOG2_WIN{1'b1}});
    assign take      = valid_i && !clear_i;
    assign push      = take && win_last;
    assign pop       = valid_o && ready_i;
    assign full      = (count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear_i) begin
            acc <= '0;
            cnt <= '0;
        end else if (valid_i) begin
            if (win_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (!wr_en && pop)
                count <= count - 1'b1;
            if (clear_i)
                ovf <= 1'b0;
            else if (push && !wr_en)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mean_mem[wr_ptr] <= mean_next;
    end

    assign valid_o    = (count != '0);
    assign count_o    = count;
    assign overflow_o = ovf;
    // Gate the head so stale storage never shows while empty or in reset.
    assign mean_o     = valid_o ? mean_mem[rd_ptr] : '0;

`ifdef CORDIC_MAG_PEAK_EN
    logic [WIDTH-1:0] pk;
    logic [WIDTH-1:0] peak_next;
    logic [WIDTH-1:0] peak_mem [FIFO_DEPTH];

    assign peak_next = (data_i > pk) ? data_i : pk;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pk <= '0;
        else if (clear_i)
            pk <= '0;
        else if (valid_i)
            pk <= win_last ? '0 : peak_next;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            peak_mem[wr_ptr] <= peak_next;
    end

    assign peak_o = valid_o ? peak_mem[rd_ptr] : '0;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_cordic_mag_avg.sv
// tb_cordic_mag_avg: directed self-checking bench for cordic_mag_avg.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_cordic_mag_avg;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        clear_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] mean_o;
    logic [31:0] peak_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cordic_mag_avg dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .mean_o     (mean_o),
        .peak_o     (peak_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk_exp(input logic [31:0] v);
`ifdef CORDIC_MAG_PEAK_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic sample(input logic [31:0] d);
        valid_i = 1'b1;
        data_i  = d;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic window(input logic [31:0] d);
        for (int i = 0; i < 16; i++)
            sample(d);
    endtask

    task automatic idle();
        @(negedge clk_i);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_mean", mean_o, 32'h0);
        check("rst_peak", peak_o, 32'h0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        ready_i = 1'b1;

        // Constant 1.0
        for (int i = 0; i < 15; i++)
            sample(32'h0001_0000);
        check("const_early", 32'(valid_o), 32'd0);
        sample(32'h0001_0000);
        check("const_valid", 32'(valid_o), 32'd1);
        check("const_mean", mean_o, 32'h0001_0000);
        check("const_peak", peak_o, pk_exp(32'h0001_0000));
        idle();
        check("const_one_cycle", 32'(valid_o), 32'd0);

        // Ramp 1.0 .. 16.0
        for (int i = 1; i <= 16; i++)
            sample(32'(i) << 16);
        check("ramp_valid", 32'(valid_o), 32'd1);
        check("ramp_mean", mean_o, 32'h0008_8000);
        check("ramp_peak", peak_o, pk_exp(32'h0010_0000));
        idle();

        // Overflow: 5 windows with no sink
        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++)
            window(32'(k) << 16);
        check("ovf_count4", 32'(count_o), 32'd4);
        check("ovf_not_yet", 32'(overflow_o), 32'd0);
        window(32'h0005_0000);
        check("ovf_count", 32'(count_o), 32'd4);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(valid_o), 32'd1);
            check($sformatf("drain%0d_mean", k), mean_o, 32'(k) << 16);
            idle();
        end
        check("drain_empty", 32'(valid_o), 32'd0);
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // Clear mid-window, same-cycle sample discarded
        for (int i = 0; i < 7; i++)
            sample(32'h0005_0000);
        clear_i = 1'b1;
        sample(32'h0005_0000);
        clear_i = 1'b0;
        check("clr_ovf", 32'(overflow_o), 32'd0);
        check("clr_no_result", 32'(valid_o), 32'd0);
        window(32'h0002_0000);
        check("clr_mean", mean_o, 32'h0002_0000);
        check("clr_peak", peak_o, pk_exp(32'h0002_0000));
        idle();

        // Full scale
        window(32'h7FFF_FFFF);
        check("fs_mean", mean_o, 32'h7FFF_FFFF);
        check("fs_peak", peak_o, pk_exp(32'h7FFF_FFFF));
        idle();

        // Push and pop in the same cycle while full
        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++)
            window(32'(k) << 16);
        for (int i = 0; i < 15; i++)
            sample(32'h0005_0000);
        ready_i = 1'b1;
        sample(32'h0005_0000);
        check("pp_count", 32'(count_o), 32'd4);
        check("pp_ovf", 32'(overflow_o), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pp%0d_mean", k), mean_o, 32'(k) << 16);
            idle();
        end
        check("pp_empty", 32'(count_o), 32'd0);

        // Asynchronous reset with results pending
        ready_i = 1'b0;
        window(32'h0007_0000);
        window(32'h0007_0000);
        for (int i = 0; i < 5; i++)
            sample(32'h0009_0000);
        check("pre_rst_count", 32'(count_o), 32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_mean", mean_o, 32'h0);
        check("arst_peak", peak_o, 32'h0);
        check("arst_count", 32'(count_o), 32'd0);
        check("arst_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        window(32'h0003_0000);
        check("post_rst_mean", mean_o, 32'h0003_0000);
        check("post_rst_count", 32'(count_o), 32'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_mag_avg.md
# cordic_mag_avg

Downstream consumer of the `cordic` magnitude stream. It accumulates fixed windows of 2^LOG2_WIN magnitude samples and produces the window mean and, optionally, the window peak. Results are queued in a small first-word-fall-through FIFO, so a back-pressured sink does not stall the `cordic` pipeline, which has no ready input. It sits between `cordic` (valid/data only) and any valid/ready consumer such as a logger or a threshold detector.

## Interface
- Q_I, 15, integer bits of the Q format (matches `cordic`)
- Q_F, 16, fractional bits of the Q format; WIDTH = Q_I+Q_F+1
- LOG2_WIN, 4, log2 of samples per window (1..8)
- FIFO_DEPTH, 4, result FIFO entries (power of 2, ≥2)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  data_i holds a magnitude sample (driven by `cordic` valid_o)
- data_i  in  WIDTH  magnitude, Q_I.Q_F, treated as unsigned
- clear_i  in  1  synchronous; discards the partial window and clears overflow_o
- valid_o  out  1  FIFO head holds a result
- ready_i  in  1  sink accepts the head when valid_o && ready_i
- mean_o  out  WIDTH  window mean at the FIFO head
- peak_o  out  WIDTH  window maximum at the FIFO head
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO fill level
- overflow_o  out  1  sticky; a completed window was dropped

## Operation
- Registers:
  - acc, WIDTH+LOG2_WIN bits; cannot overflow.
  - cnt, LOG2_WIN bits.
  - pk, WIDTH bits.
  - FIFO of {mean, peak}.
- Sample with cnt < WIN-1 (WIN = 2^LOG2_WIN):
  - acc += data_i
  - pk = max(pk, data_i)
  - cnt++
- Sample with cnt == WIN-1 (window completes):
  - mean = (acc+data_i) >> LOG2_WIN, truncated toward zero.
  - peak = max(pk, data_i).
  - Push {mean, peak}.
  - acc, cnt, pk return to 0.
- Push when FIFO is full and no pop occurs in the same cycle: the result is dropped and overflow_o is set to 1.
  - Window state still resets.
  - overflow_o holds until rst_i or clear_i.
- Push and pop in the same cycle are both performed, including when the FIFO is full. count_o is unchanged.
- Pop when empty: ignored. ready_i is don't-care while valid_o is 0.
- clear_i:
  - Zeroes acc, cnt, pk and overflow_o.
  - Does not flush the FIFO.
  - A valid_i in the same cycle is discarded; clear wins.
- Reset: all outputs are 0 (valid_o, mean_o, peak_o, count_o, overflow_o), the FIFO is empty and the partial window is lost. Asserting rst_i mid-window or while results are pending drops everything.
- Samples are never dropped while valid_i is high; there is no input handshake.

## Timing
- Result latency:
  - valid_o rises in the cycle after the edge that captures the window's last sample, when the FIFO was empty.
  - mean_o and peak_o are stable in that same cycle.
- The FIFO is first-word-fall-through. mean_o and peak_o change only on a pop or when an empty FIFO receives a push.
- Pop: valid_o && ready_i sampled on an edge advances the head on that edge.
- count_o updates on the same edge as the push/pop.
- overflow_o rises on the edge of the dropped push.
- Sustained throughput: one sample per cycle; one result every WIN cycles.

## Configuration
- CORDIC_MAG_PEAK_EN defined:
  - pk register and peak FIFO field are present.
  - peak_o reports the window maximum.
- CORDIC_MAG_PEAK_EN undefined:
  - pk and the peak field are removed.
  - peak_o is tied to 0.
  - Mean, overflow and timing behaviour are identical.

## Test plan
- Mean of constant input: 16 consecutive samples of 1.0 (0x00010000), ready_i=1 → one result, mean_o=0x00010000, peak_o=0x00010000. valid_o high for exactly 1 cycle, in the cycle after the 16th sample edge.
- Mean of a ramp: samples 1.0..16.0 → sum 136.0, mean_o=0x00088000 (8.5), peak_o=0x00100000. Repeat with CORDIC_MAG_PEAK_EN undefined → same mean_o, peak_o=0.
- FIFO overflow: ready_i=0, 5 windows → count_o=4, overflow_o=1 after the 5th window's last edge. Then ready_i=1 → the first 4 results drain in order and valid_o drops.
- Clear during a window: 7 samples of 5.0, then clear_i with valid_i=1 on the same cycle, then 16 samples of 2.0 → mean_o=0x00020000. The 5.0 samples and the same-cycle sample have no effect.
- Full-scale input: 16 samples of 0x7FFFFFFF → mean_o=0x7FFFFFFF, no wrap.
- Reset: rst_i asserted mid-window with 2 results queued → all outputs 0 immediately, without waiting for a clock edge. After release, a fresh 16-sample window of 3.0 → mean_o=0x00030000.
